// File: rtl/pla_eval_pipe.sv
// Run-time programmable PLA (AND plane + OR plane) behind a 2-stage valid/ready pipeline.
// Result appears 2 cycles after acceptance; at most 2 vectors in flight; outputs hold while out_ready is low.
module pla_eval_pipe #(
  parameter int N_IN    = 6,
  parameter int N_TERMS = 7,
  parameter int N_OUT   = 7,
  parameter int IDX_W   = (N_TERMS > 1) ? $clog2(N_TERMS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic               cfg_en,
  input  logic [N_IN-1:0]    cfg_care,
  input  logic [N_IN-1:0]    cfg_val,
  input  logic [N_OUT-1:0]   cfg_or,
  output logic               cfg_ready,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_IN-1:0]    in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_OUT-1:0]   out_y,
  output logic [N_TERMS-1:0] out_terms,
  output logic               out_any,
  output logic [IDX_W-1:0]   out_first
);

  logic [N_TERMS-1:0] row_en;
  logic [N_IN-1:0]    row_care [N_TERMS];
  logic [N_IN-1:0]    row_val  [N_TERMS];
  logic [N_OUT-1:0]   row_or   [N_TERMS];

  logic               s1_valid;
  logic [N_TERMS-1:0] s1_hits;
  logic               s2_load;
  logic               s1_adv;
  logic               in_fire;
  logic               cfg_fire;
  logic [N_TERMS-1:0] hit;
  logic [N_OUT-1:0]   y_nxt;
  logic [IDX_W-1:0]   first_nxt;

  // Config rows may only change with the pipeline empty, so the OR plane
  // can safely be read in stage 2 without being captured alongside the hits.
  assign cfg_ready = ~s1_valid & ~out_valid;
  assign cfg_fire  = cfg_we & cfg_ready;
  assign s2_load   = ~out_valid | out_ready;
  assign s1_adv    = s1_valid & s2_load;
  assign in_ready  = (~s1_valid | s1_adv) & ~cfg_fire;
  assign in_fire   = in_valid & in_ready;

  always_comb begin
    hit = '0;
    for (int t = 0; t < N_TERMS; t++) begin
      hit[t] = row_en[t] & (((in_data ^ row_val[t]) & row_care[t]) == '0);
    end
  end

  // Scan high to low so the lowest hitting index is the last one written.
  always_comb begin
    y_nxt     = '0;
    first_nxt = '0;
    for (int t = N_TERMS - 1; t >= 0; t--) begin
      if (s1_hits[t]) begin
        y_nxt     = y_nxt | row_or[t];
        first_nxt = IDX_W'(t);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_en <= '0;
      for (int t = 0; t < N_TERMS; t++) begin
        row_care[t] <= '0;
        row_val[t]  <= '0;
        row_or[t]   <= '0;
      end
    end else if (cfg_fire) begin
      for (int t = 0; t < N_TERMS; t++) begin
        if (int'(cfg_idx) == t) begin
          row_en[t]   <= cfg_en;
          row_care[t] <= cfg_care;
          row_val[t]  <= cfg_val;
          row_or[t]   <= cfg_or;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_hits   <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_terms <= '0;
      out_any   <= 1'b0;
      out_first <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_hits  <= hit;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_terms <= s1_hits;
          out_y     <= y_nxt;
          out_any   <= |s1_hits;
          out_first <= first_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_pla_eval_pipe.sv
// Bench for pla_eval_pipe: directed vector table, multi-cycle corner sequences,
// and random traffic scored against a per-variable reference model.
module tb_pla_eval_pipe;
  localparam int N_IN = 6, N_TERMS = 7, N_OUT = 7, IDX_W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cfg_we = 1'b0;
  logic [IDX_W-1:0] cfg_idx = '0;
  logic cfg_en = 1'b0;
  logic [N_IN-1:0] cfg_care = '0, cfg_val = '0;
  logic [N_OUT-1:0] cfg_or = '0;
  logic cfg_ready;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [N_IN-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [N_OUT-1:0] out_y;
  logic [N_TERMS-1:0] out_terms;
  logic out_any;
  logic [IDX_W-1:0] out_first;

  always #5 clk = ~clk;

  pla_eval_pipe #(.N_IN(N_IN), .N_TERMS(N_TERMS), .N_OUT(N_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_care(cfg_care),
    .cfg_val(cfg_val), .cfg_or(cfg_or), .cfg_ready(cfg_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_terms(out_terms), .out_any(out_any), .out_first(out_first)
  );

  typedef struct packed {
    logic [N_OUT-1:0]   y;
    logic [N_TERMS-1:0] terms;
    logic               any;
    logic [IDX_W-1:0]   first;
  } res_t;

  typedef struct {
    logic [N_IN-1:0] d;
    res_t            e;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference configuration, updated whenever a write handshake is seen.
  logic            m_en   [N_TERMS];
  logic [N_IN-1:0] m_care [N_TERMS];
  logic [N_IN-1:0] m_val  [N_TERMS];
  logic [N_OUT-1:0] m_or  [N_TERMS];

  function automatic res_t model(input logic [N_IN-1:0] d);
    res_t r;
    logic h;
    r = '0;
    for (int t = 0; t < N_TERMS; t++) begin
      h = m_en[t];
      for (int v = 0; v < N_IN; v++)
        if (m_care[t][v] && (d[v] != m_val[t][v])) h = 1'b0;
      if (h) begin
        r.terms[t] = 1'b1;
        r.y = r.y | m_or[t];
        if (!r.any) begin
          r.first = IDX_W'(t);
          r.any   = 1'b1;
        end
      end
    end
    return r;
  endfunction

  res_t exp_q[$];
  res_t snap;
  res_t popped;
  logic held = 1'b0;
  int   pops = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      held = 1'b0;
      for (int t = 0; t < N_TERMS; t++) begin
        m_en[t] = 1'b0; m_care[t] = '0; m_val[t] = '0; m_or[t] = '0;
      end
      chk("rst_out_valid", 32'(out_valid), 32'd0);
    end else begin
      chk("cfg_ready_empty", 32'(cfg_ready), 32'(exp_q.size() == 0));
      if (exp_q.size() == 0) chk("idle_out_valid", 32'(out_valid), 32'd0);
      if (cfg_we && cfg_ready) chk("cfg_prio_in_ready", 32'(in_ready), 32'd0);
      if (exp_q.size() >= 2 && !out_ready) chk("full_in_ready", 32'(in_ready), 32'd0);
      if (held) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'({out_y, out_terms, out_any, out_first}), 32'(snap));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out_qsize", 32'(exp_q.size()), 32'd1);
        else begin
          popped = exp_q.pop_front();
          chk("out_data", 32'({out_y, out_terms, out_any, out_first}), 32'(popped));
          pops++;
        end
      end
      if (cfg_we && cfg_ready && (int'(cfg_idx) < N_TERMS)) begin
        m_en[cfg_idx] = cfg_en; m_care[cfg_idx] = cfg_care;
        m_val[cfg_idx] = cfg_val; m_or[cfg_idx] = cfg_or;
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_data));
      held = out_valid && !out_ready;
      snap = {out_y, out_terms, out_any, out_first};
    end
  end

  task automatic wait_in_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) chk("tmo_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic wait_cfg_ready();
    int n = 0;
    @(negedge clk);
    while (!cfg_ready && n < 50) begin @(negedge clk); n++; end
    if (!cfg_ready) chk("tmo_cfg_ready", 32'(cfg_ready), 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) chk("tmo_drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send(input logic [N_IN-1:0] d);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d;
    wait_in_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic [IDX_W-1:0] idx, input logic en,
                           input logic [N_IN-1:0] care, input logic [N_IN-1:0] val,
                           input logic [N_OUT-1:0] o);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_care = care; cfg_val = val; cfg_or = o;
    wait_cfg_ready();
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Call right after send(): result must be absent one cycle later, present two.
  task automatic expect_after2(input string name, input res_t e);
    @(negedge clk);
    chk({name, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({name, "_lat2"}, 32'(out_valid), 32'd1);
    chk({name, "_terms"}, 32'(out_terms), 32'(e.terms));
    chk({name, "_y"}, 32'(out_y), 32'(e.y));
    chk({name, "_any"}, 32'(out_any), 32'(e.any));
    chk({name, "_first"}, 32'(out_first), 32'(e.first));
  endtask

  logic [N_IN-1:0] lc [N_TERMS] = '{6'b011010, 6'b101010, 6'b111001, 6'b011111,
                                    6'b011111, 6'b111101, 6'b110111};
  logic [N_IN-1:0] lv [N_TERMS] = '{6'b010010, 6'b100010, 6'b101001, 6'b010111,
                                    6'b000111, 6'b001101, 6'b000000};
  vec_t tbl [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int p0;
    // Expected values derived by hand from the legacy map (one-hot OR rows).
    tbl[0] = '{6'b010010, '{7'b0000001, 7'b0000001, 1'b1, 3'd0}};
    tbl[1] = '{6'b000000, '{7'b1000000, 7'b1000000, 1'b1, 3'd6}};
    tbl[2] = '{6'b001000, '{7'b1000000, 7'b1000000, 1'b1, 3'd6}};
    tbl[3] = '{6'b111111, '{7'b0000000, 7'b0000000, 1'b0, 3'd0}};
    tbl[4] = '{6'b010111, '{7'b0001001, 7'b0001001, 1'b1, 3'd0}};
    tbl[5] = '{6'b000111, '{7'b0010000, 7'b0010000, 1'b1, 3'd4}};

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_y", 32'(out_y), 32'd0);
    chk("reset_out_terms", 32'(out_terms), 32'd0);
    chk("reset_out_first", 32'(out_first), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    for (int r = 0; r < N_TERMS; r++) cfg_write(IDX_W'(r), 1'b1, lc[r], lv[r], 7'(1 << r));
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].d);
      expect_after2($sformatf("legacy%0d", i), tbl[i].e);
    end

    // Shared OR plane, two vectors back to back.
    cfg_write(3'd0, 1'b1, lc[0], lv[0], 7'b0000011);
    cfg_write(3'd6, 1'b1, lc[6], lv[6], 7'b0000001);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 6'b010010;
    wait_in_ready();
    @(posedge clk); #1;
    in_data = 6'b000000;
    @(negedge clk);
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid0", 32'(out_valid), 32'd1);
    chk("b2b_y0", 32'(out_y), 32'b0000011);
    @(negedge clk);
    chk("b2b_valid1", 32'(out_valid), 32'd1);
    chk("b2b_y1", 32'(out_y), 32'b0000001);
    wait_drain();

    // Backpressure: third vector must stall until the sink opens.
    @(posedge clk); #1 out_ready = 1'b0;
    p0 = pops;
    send(6'b010010);
    send(6'b000000);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 6'b000111;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_in_ready();
    @(posedge clk); #1 in_valid = 1'b0;
    wait_drain();
    chk("bp_pop_count", 32'(pops - p0), 32'd3);

    // Write attempt while busy is ignored.
    @(posedge clk); #1 out_ready = 1'b0;
    send(6'b010010);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_en = 1'b0; cfg_care = '0; cfg_val = '0; cfg_or = '0;
    @(negedge clk);
    chk("il1_cfg_ready", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    chk("il1_cfg_ready2", 32'(cfg_ready), 32'd0);
    @(posedge clk); #1;
    cfg_we = 1'b0; out_ready = 1'b1;
    wait_drain();
    send(6'b010010);
    expect_after2("il1_row_kept", '{7'b0000011, 7'b0000001, 1'b1, 3'd0});

    // Write and vector offered together on an empty pipeline: write wins.
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_en = 1'b0; cfg_care = '0; cfg_val = '0; cfg_or = '0;
    in_valid = 1'b1; in_data = 6'b010010;
    @(negedge clk);
    chk("il2_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("il2_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1 cfg_we = 1'b0;
    wait_in_ready();
    @(posedge clk); #1 in_valid = 1'b0;
    expect_after2("il2_new_row", '0);

    // Out-of-range index completes the handshake but alters nothing.
    cfg_write(3'd7, 1'b1, 6'b000000, 6'b000000, 7'h7f);
    send(6'b111111);
    expect_after2("il3_idx7", '0);

    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 6'($urandom);
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_idx   = 3'($urandom);
      cfg_en    = 1'($urandom);
      cfg_care  = 6'($urandom & $urandom);
      cfg_val   = 6'($urandom);
      cfg_or    = 7'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    wait_drain();

    // Reset with two vectors in flight; config must come back cleared.
    for (int r = 0; r < N_TERMS; r++) cfg_write(IDX_W'(r), 1'b1, 6'b000000, 6'b000000, 7'h7f);
    @(posedge clk); #1 out_ready = 1'b0;
    send(6'b000000);
    send(6'b111111);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_y", 32'(out_y), 32'd0);
    chk("mid_rst_out_terms", 32'(out_terms), 32'd0);
    chk("mid_rst_out_any", 32'(out_any), 32'd0);
    chk("mid_rst_out_first", 32'(out_first), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(6'($urandom));
      expect_after2($sformatf("post_rst%0d", i), '0);
    end
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
